// File: rtl/ocp3_nic_pkg.sv
// rtl/ocp3_nic_pkg.sv - shared state encodings and fault codes for the NIC power monitor
package ocp3_nic_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AUX_WAIT  = 3'd1,
    ST_AUX_ON    = 3'd2,
    ST_MAIN_WAIT = 3'd3,
    ST_MAIN_ON   = 3'd4,
    ST_FAULT     = 3'd5
  } mon_state_t;

  localparam logic [CODE_W-1:0] FC_NONE      = 3'd0;
  localparam logic [CODE_W-1:0] FC_AUX_TO    = 3'd1;
  localparam logic [CODE_W-1:0] FC_AUX_LOSS  = 3'd2;
  localparam logic [CODE_W-1:0] FC_MAIN_TO   = 3'd3;
  localparam logic [CODE_W-1:0] FC_MAIN_LOSS = 3'd4;
  localparam logic [CODE_W-1:0] FC_REMOVED   = 3'd5;

endpackage

// File: rtl/ocp3_nic_slot_mon.sv
// rtl/ocp3_nic_slot_mon.sv - one NIC slot: input synchronisers, supervisor FSM, timeout and loss-filter counters
module ocp3_nic_slot_mon
  import ocp3_nic_pkg::*;
#(
  parameter int AUX_TIMEOUT_MS  = 50,
  parameter int MAIN_TIMEOUT_MS = 100,
  parameter int GLITCH_CYC      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              fault_clr,
  input  logic              prsnt_n,
  input  logic              aux_en,
  input  logic              main_en,
  input  logic              pg_p12v,
  input  logic              pg_p3v3,
  input  logic              pg_main,
  output logic              fault,
  output logic [CODE_W-1:0] fault_code,
  output logic [2:0]        state
);

  localparam logic [7:0] AUX_LIM  = 8'(AUX_TIMEOUT_MS);
  localparam logic [7:0] MAIN_LIM = 8'(MAIN_TIMEOUT_MS);
  localparam logic [7:0] GLITCH   = 8'(GLITCH_CYC);

  logic [5:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {prsnt_n, aux_en, main_en, pg_p12v, pg_p3v3, pg_main};
      sync2 <= sync1;
    end
  end

  logic present, aux_en_s, main_en_s, aux_pg, main_pg;
  assign present   = ~sync2[5];
  assign aux_en_s  = sync2[4];
  assign main_en_s = sync2[3];
  assign aux_pg    = sync2[2] & sync2[1];
  assign main_pg   = sync2[0];

  mon_state_t        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [7:0]        ms_cnt, aux_lo_cnt, main_lo_cnt;

  logic in_wait, aux_req, main_req;
  assign in_wait  = (state_q == ST_AUX_WAIT) || (state_q == ST_MAIN_WAIT);
  assign aux_req  = state_q inside {ST_AUX_ON, ST_MAIN_WAIT, ST_MAIN_ON};
  assign main_req = (state_q == ST_MAIN_ON);

  // Counter sits at zero outside the WAIT states, so every WAIT entry starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt      <= '0;
      aux_lo_cnt  <= '0;
      main_lo_cnt <= '0;
    end else begin
      if (!in_wait)                  ms_cnt <= '0;
      else if (tick && ms_cnt != 8'hFF) ms_cnt <= ms_cnt + 8'd1;

      if (!aux_req || aux_pg)        aux_lo_cnt <= '0;
      else if (aux_lo_cnt != GLITCH) aux_lo_cnt <= aux_lo_cnt + 8'd1;

      if (!main_req || main_pg)        main_lo_cnt <= '0;
      else if (main_lo_cnt != GLITCH)  main_lo_cnt <= main_lo_cnt + 8'd1;
    end
  end

  logic aux_loss, main_loss, tick_hit, aux_to, main_to;
  assign aux_loss  = (aux_lo_cnt == GLITCH);
  assign main_loss = (main_lo_cnt == GLITCH);
  assign tick_hit  = tick && (ms_cnt != 8'hFF);
  assign aux_to    = tick_hit && ((ms_cnt + 8'd1) == AUX_LIM);
  assign main_to   = tick_hit && ((ms_cnt + 8'd1) == MAIN_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Branch order inside each state encodes the event priority.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (aux_en_s && present) state_d = ST_AUX_WAIT;
      end
      ST_AUX_WAIT: begin
        if (!present)      begin state_d = ST_FAULT; code_d = FC_REMOVED; end
        else if (aux_to)   begin state_d = ST_FAULT; code_d = FC_AUX_TO;  end
        else if (!aux_en_s) state_d = ST_IDLE;
        else if (aux_pg)    state_d = ST_AUX_ON;
      end
      ST_AUX_ON: begin
        if (!present)       begin state_d = ST_FAULT; code_d = FC_REMOVED;  end
        else if (aux_loss)  begin state_d = ST_FAULT; code_d = FC_AUX_LOSS; end
        else if (!aux_en_s) state_d = ST_IDLE;
        else if (main_en_s) state_d = ST_MAIN_WAIT;
      end
      ST_MAIN_WAIT: begin
        if (!present)        begin state_d = ST_FAULT; code_d = FC_REMOVED;  end
        else if (aux_loss)   begin state_d = ST_FAULT; code_d = FC_AUX_LOSS; end
        else if (main_to)    begin state_d = ST_FAULT; code_d = FC_MAIN_TO;  end
        else if (!main_en_s) state_d = ST_AUX_ON;
        else if (main_pg)    state_d = ST_MAIN_ON;
      end
      ST_MAIN_ON: begin
        if (!present)        begin state_d = ST_FAULT; code_d = FC_REMOVED;   end
        else if (aux_loss)   begin state_d = ST_FAULT; code_d = FC_AUX_LOSS;  end
        else if (main_loss)  begin state_d = ST_FAULT; code_d = FC_MAIN_LOSS; end
        else if (!main_en_s) state_d = ST_AUX_ON;
      end
      ST_FAULT: begin
        if (fault_clr && !aux_en_s) begin state_d = ST_IDLE; code_d = FC_NONE; end
      end
      default: begin
        state_d = ST_IDLE;
        code_d  = FC_NONE;
      end
    endcase
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;
  assign state      = state_q;

endmodule

// File: rtl/ocp3_nic_pwr_monitor.sv
// rtl/ocp3_nic_pwr_monitor.sv - two-slot OCP3 NIC power-fault supervisor; aggregates per-slot monitors
module ocp3_nic_pwr_monitor
  import ocp3_nic_pkg::*;
#(
  parameter int AUX_TIMEOUT_MS  = 50,
  parameter int MAIN_TIMEOUT_MS = 100,
  parameter int GLITCH_CYC      = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iTick_1ms,
  input  logic              iFault_Clr,
  input  logic              iPRSNT_NIC0_N,
  input  logic              iPRSNT_NIC1_N,
  input  logic              iNIC0_AUX_PWR_EN,
  input  logic              iNIC0_MAIN_PWR_EN,
  input  logic              iNIC1_AUX_PWR_EN,
  input  logic              iNIC1_MAIN_PWR_EN,
  input  logic              iPWRGD_P12V_NIC0,
  input  logic              iPWRGD_P3V3_NIC0,
  input  logic              iPWRGD_NIC0_PWR_GOOD,
  input  logic              iPWRGD_P12V_NIC1,
  input  logic              iPWRGD_P3V3_NIC1,
  input  logic              iPWRGD_NIC1_PWR_GOOD,
  output logic              oNIC0_FAULT,
  output logic [CODE_W-1:0] oNIC0_FAULT_CODE,
  output logic              oNIC1_FAULT,
  output logic [CODE_W-1:0] oNIC1_FAULT_CODE,
  output logic              oNIC_FAULT_N,
  output logic [5:0]        oNIC_MON_FSM
);

  logic [2:0] state0, state1;

  ocp3_nic_slot_mon #(
    .AUX_TIMEOUT_MS (AUX_TIMEOUT_MS),
    .MAIN_TIMEOUT_MS(MAIN_TIMEOUT_MS),
    .GLITCH_CYC     (GLITCH_CYC)
  ) u_slot0 (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .tick      (iTick_1ms),
    .fault_clr (iFault_Clr),
    .prsnt_n   (iPRSNT_NIC0_N),
    .aux_en    (iNIC0_AUX_PWR_EN),
    .main_en   (iNIC0_MAIN_PWR_EN),
    .pg_p12v   (iPWRGD_P12V_NIC0),
    .pg_p3v3   (iPWRGD_P3V3_NIC0),
    .pg_main   (iPWRGD_NIC0_PWR_GOOD),
    .fault     (oNIC0_FAULT),
    .fault_code(oNIC0_FAULT_CODE),
    .state     (state0)
  );

  ocp3_nic_slot_mon #(
    .AUX_TIMEOUT_MS (AUX_TIMEOUT_MS),
    .MAIN_TIMEOUT_MS(MAIN_TIMEOUT_MS),
    .GLITCH_CYC     (GLITCH_CYC)
  ) u_slot1 (
    .clk       (iClk),
    .rst_n     (iRst_n),
    .tick      (iTick_1ms),
    .fault_clr (iFault_Clr),
    .prsnt_n   (iPRSNT_NIC1_N),
    .aux_en    (iNIC1_AUX_PWR_EN),
    .main_en   (iNIC1_MAIN_PWR_EN),
    .pg_p12v   (iPWRGD_P12V_NIC1),
    .pg_p3v3   (iPWRGD_P3V3_NIC1),
    .pg_main   (iPWRGD_NIC1_PWR_GOOD),
    .fault     (oNIC1_FAULT),
    .fault_code(oNIC1_FAULT_CODE),
    .state     (state1)
  );

  assign oNIC_FAULT_N = ~(oNIC0_FAULT | oNIC1_FAULT);
  assign oNIC_MON_FSM = {state0, state1};

endmodule

// File: tb/tb_ocp3_nic_pwr_monitor.sv
// tb/tb_ocp3_nic_pwr_monitor.sv - directed self-checking bench for the two-slot NIC power monitor
module tb_ocp3_nic_pwr_monitor;
  import ocp3_nic_pkg::*;

  localparam int TICK_DIV = 20;

  logic iClk = 0, iRst_n = 0, iTick_1ms = 0, iFault_Clr = 0;
  logic iPRSNT_NIC0_N = 1, iPRSNT_NIC1_N = 1;
  logic iNIC0_AUX_PWR_EN = 0, iNIC0_MAIN_PWR_EN = 0;
  logic iNIC1_AUX_PWR_EN = 0, iNIC1_MAIN_PWR_EN = 0;
  logic iPWRGD_P12V_NIC0 = 0, iPWRGD_P3V3_NIC0 = 0, iPWRGD_NIC0_PWR_GOOD = 0;
  logic iPWRGD_P12V_NIC1 = 0, iPWRGD_P3V3_NIC1 = 0, iPWRGD_NIC1_PWR_GOOD = 0;
  logic       oNIC0_FAULT, oNIC1_FAULT, oNIC_FAULT_N;
  logic [2:0] oNIC0_FAULT_CODE, oNIC1_FAULT_CODE;
  logic [5:0] oNIC_MON_FSM;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  ocp3_nic_pwr_monitor dut (
    .iClk(iClk), .iRst_n(iRst_n), .iTick_1ms(iTick_1ms), .iFault_Clr(iFault_Clr),
    .iPRSNT_NIC0_N(iPRSNT_NIC0_N), .iPRSNT_NIC1_N(iPRSNT_NIC1_N),
    .iNIC0_AUX_PWR_EN(iNIC0_AUX_PWR_EN), .iNIC0_MAIN_PWR_EN(iNIC0_MAIN_PWR_EN),
    .iNIC1_AUX_PWR_EN(iNIC1_AUX_PWR_EN), .iNIC1_MAIN_PWR_EN(iNIC1_MAIN_PWR_EN),
    .iPWRGD_P12V_NIC0(iPWRGD_P12V_NIC0), .iPWRGD_P3V3_NIC0(iPWRGD_P3V3_NIC0),
    .iPWRGD_NIC0_PWR_GOOD(iPWRGD_NIC0_PWR_GOOD),
    .iPWRGD_P12V_NIC1(iPWRGD_P12V_NIC1), .iPWRGD_P3V3_NIC1(iPWRGD_P3V3_NIC1),
    .iPWRGD_NIC1_PWR_GOOD(iPWRGD_NIC1_PWR_GOOD),
    .oNIC0_FAULT(oNIC0_FAULT), .oNIC0_FAULT_CODE(oNIC0_FAULT_CODE),
    .oNIC1_FAULT(oNIC1_FAULT), .oNIC1_FAULT_CODE(oNIC1_FAULT_CODE),
    .oNIC_FAULT_N(oNIC_FAULT_N), .oNIC_MON_FSM(oNIC_MON_FSM)
  );

  initial forever #5 iClk = ~iClk;

  // Compressed millisecond strobe: one tick every TICK_DIV clocks.
  initial forever begin
    repeat (TICK_DIV - 1) @(negedge iClk);
    iTick_1ms = 1;
    @(negedge iClk);
    iTick_1ms = 0;
  end

  always @(posedge iClk) if (iTick_1ms) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] slot_state(input int slot);
    return (slot != 0) ? oNIC_MON_FSM[2:0] : oNIC_MON_FSM[5:3];
  endfunction

  task automatic wait_fsm(input string tag, input int slot, input logic [2:0] st, input int budget);
    int n = 0;
    while (slot_state(slot) != st && n < budget) begin
      @(negedge iClk);
      n++;
    end
    check(tag, 32'(slot_state(slot)), 32'(st));
  endtask

  task automatic pulse_clr();
    @(negedge iClk) iFault_Clr = 1;
    @(negedge iClk) iFault_Clr = 0;
  endtask

  initial begin
    int t0, delta;

    repeat (3) @(negedge iClk);
    check("rst_fault0", 32'(oNIC0_FAULT), 32'd0);
    check("rst_code0", 32'(oNIC0_FAULT_CODE), 32'(FC_NONE));
    check("rst_fault_n", 32'(oNIC_FAULT_N), 32'd1);
    check("rst_fsm", 32'(oNIC_MON_FSM), 32'd0);
    iRst_n = 1;

    // Ramp timeout: aux power-good never arrives.
    iPRSNT_NIC0_N = 0;
    iNIC0_AUX_PWR_EN = 1;
    wait_fsm("to_aux_wait", 0, ST_AUX_WAIT, 10);
    t0 = tick_cnt;
    wait_fsm("to_fault", 0, ST_FAULT, 60 * TICK_DIV);
    delta = tick_cnt - t0;
    check("to_ticks", 32'(delta), 32'd50);
    check("to_code", 32'(oNIC0_FAULT_CODE), 32'(FC_AUX_TO));
    check("to_fault_n", 32'(oNIC_FAULT_N), 32'd0);

    // Clear is ignored while AUX_EN is still high.
    pulse_clr();
    repeat (2) @(negedge iClk);
    check("clr_ignored", 32'(slot_state(0)), 32'(ST_FAULT));
    iNIC0_AUX_PWR_EN = 0;
    repeat (4) @(negedge iClk);
    pulse_clr();
    check("clr_state", 32'(slot_state(0)), 32'(ST_IDLE));
    check("clr_code", 32'(oNIC0_FAULT_CODE), 32'(FC_NONE));

    // Normal ramp: aux after 10 ms, PWR_GOOD 20 ms after MAIN_EN.
    iNIC0_AUX_PWR_EN = 1;
    wait_fsm("nr_aux_wait", 0, ST_AUX_WAIT, 10);
    repeat (10 * TICK_DIV) @(negedge iClk);
    iPWRGD_P12V_NIC0 = 1;
    iPWRGD_P3V3_NIC0 = 1;
    wait_fsm("nr_aux_on", 0, ST_AUX_ON, 10);
    iNIC0_MAIN_PWR_EN = 1;
    wait_fsm("nr_main_wait", 0, ST_MAIN_WAIT, 10);
    repeat (20 * TICK_DIV) @(negedge iClk);
    iPWRGD_NIC0_PWR_GOOD = 1;
    wait_fsm("nr_main_on", 0, ST_MAIN_ON, 10);
    check("nr_fault", 32'(oNIC0_FAULT), 32'd0);
    check("nr_fault_n", 32'(oNIC_FAULT_N), 32'd1);

    // Glitch filter: 3-cycle drop filtered, 4-cycle drop faults 7 cycles after the fall.
    iPWRGD_NIC0_PWR_GOOD = 0;
    repeat (3) @(negedge iClk);
    iPWRGD_NIC0_PWR_GOOD = 1;
    repeat (10) @(negedge iClk);
    check("gl3_state", 32'(slot_state(0)), 32'(ST_MAIN_ON));
    check("gl3_fault", 32'(oNIC0_FAULT), 32'd0);
    iPWRGD_NIC0_PWR_GOOD = 0;
    repeat (4) @(negedge iClk);
    iPWRGD_NIC0_PWR_GOOD = 1;
    repeat (2) @(negedge iClk);
    check("gl4_cyc6", 32'(slot_state(0)), 32'(ST_MAIN_ON));
    @(negedge iClk);
    check("gl4_cyc7", 32'(slot_state(0)), 32'(ST_FAULT));
    check("gl4_code", 32'(oNIC0_FAULT_CODE), 32'(FC_MAIN_LOSS));

    iNIC0_AUX_PWR_EN = 0;
    iNIC0_MAIN_PWR_EN = 0;
    repeat (4) @(negedge iClk);
    pulse_clr();
    check("clr2_state", 32'(slot_state(0)), 32'(ST_IDLE));

    // Priority: removal and P3V3 drop in the same cycle.
    iNIC0_AUX_PWR_EN = 1;
    iNIC0_MAIN_PWR_EN = 1;
    wait_fsm("pr_main_on", 0, ST_MAIN_ON, 20);
    iPRSNT_NIC0_N = 1;
    iPWRGD_P3V3_NIC0 = 0;
    repeat (2) @(negedge iClk);
    check("pr_cyc2", 32'(oNIC0_FAULT), 32'd0);
    @(negedge iClk);
    check("pr_cyc3", 32'(oNIC0_FAULT), 32'd1);
    check("pr_code", 32'(oNIC0_FAULT_CODE), 32'(FC_REMOVED));
    repeat (10) @(negedge iClk);
    check("pr_code_sticky", 32'(oNIC0_FAULT_CODE), 32'(FC_REMOVED));

    // Independence and asynchronous reset mid-MAIN_WAIT on slot1.
    iPRSNT_NIC1_N = 0;
    iPWRGD_P12V_NIC1 = 1;
    iPWRGD_P3V3_NIC1 = 1;
    iNIC1_AUX_PWR_EN = 1;
    iNIC1_MAIN_PWR_EN = 1;
    wait_fsm("ind_main_wait", 1, ST_MAIN_WAIT, 20);
    check("ind_slot0_code", 32'(oNIC0_FAULT_CODE), 32'(FC_REMOVED));
    check("ind_slot1_fault", 32'(oNIC1_FAULT), 32'd0);
    #2 iRst_n = 0;
    #1;
    check("ar_fsm", 32'(oNIC_MON_FSM), 32'd0);
    check("ar_fault0", 32'(oNIC0_FAULT), 32'd0);
    check("ar_code0", 32'(oNIC0_FAULT_CODE), 32'(FC_NONE));
    check("ar_fault1", 32'(oNIC1_FAULT), 32'd0);
    check("ar_fault_n", 32'(oNIC_FAULT_N), 32'd1);
    @(negedge iClk) iRst_n = 1;
    repeat (2) @(negedge iClk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
